// File: rtl/pixel_stream_source.sv
// Raster-order frame RAM reader driving a pixel/valid/ready stream with frame and line markers.
// Optional horizontal blanking is compiled in with the PIXEL_SRC_HBLANK_EN macro.
module pixel_stream_source #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12,
    parameter int HBLANK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        pixel,
    output logic              pixel_valid,
    input  logic              pixel_ready,
    output logic              sof,
    output logic              eol,
    output logic              eof
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam int ENT_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
`ifdef PIXEL_SRC_HBLANK_EN
        ST_BLANK  = 2'd3,
`endif
        ST_DRAIN  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              inflight_q;
    logic [2:0]        rd_mk_q;
    logic [ENT_W-1:0]  ent0_q, ent1_q;
    logic [1:0]        cnt_q;
    logic              done_q;

    logic              issue_s, pop_s, line_end_s, frame_end_s, eof_xfer_s;
    logic [2:0]        level_s;
    logic [ENT_W-1:0]  head_s;

`ifdef PIXEL_SRC_HBLANK_EN
    localparam int BW = (HBLANK > 1) ? $clog2(HBLANK) : 1;
    localparam logic [BW-1:0] BLANK_LAST = BW'(HBLANK - 1);
    logic [BW-1:0] blank_q, blank_d;
`else
    if (HBLANK < 0) begin : g_hblank_unused
    end
`endif

    assign line_end_s  = (x_q == X_LAST);
    assign frame_end_s = line_end_s && (y_q == Y_LAST);

    // Output comb: skid head (or read data falling straight through) and read issue
    always_comb begin
        pixel_valid = (cnt_q != 2'd0) || inflight_q;
        if ((cnt_q == 2'd0) && inflight_q) begin
            head_s = {mem_rdata, rd_mk_q};
        end else begin
            head_s = ent0_q;
        end
        pixel      = head_s[10:3];
        sof        = pixel_valid & head_s[2];
        eol        = pixel_valid & head_s[1];
        eof        = pixel_valid & head_s[0];
        pop_s      = pixel_valid & pixel_ready;
        eof_xfer_s = pop_s & eof;
        // Buffered-after-this-edge count; keeps at most 2 pixels held or in flight
        level_s    = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        issue_s    = (state_q == ST_STREAM) && (level_s < 3'd2);
        mem_rd     = issue_s;
        mem_addr   = addr_q;
        busy       = (state_q != ST_IDLE);
        done       = done_q;
    end

    // Next-state comb
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_STREAM;
                else       state_d = ST_IDLE;
            end
            ST_STREAM: begin
                if (issue_s && frame_end_s) begin
                    state_d = ST_DRAIN;
                end else if (issue_s && line_end_s) begin
`ifdef PIXEL_SRC_HBLANK_EN
                    if (HBLANK > 0) state_d = ST_BLANK;
                    else            state_d = ST_STREAM;
`else
                    state_d = ST_STREAM;
`endif
                end else begin
                    state_d = ST_STREAM;
                end
            end
`ifdef PIXEL_SRC_HBLANK_EN
            ST_BLANK: begin
                if (blank_q == BLANK_LAST) state_d = ST_STREAM;
                else                       state_d = ST_BLANK;
            end
`endif
            ST_DRAIN: begin
                if (eof_xfer_s) state_d = ST_IDLE;
                else            state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Raster counters and read address next values
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (state_q == ST_IDLE) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
        end else if (issue_s) begin
            if (frame_end_s) begin
                x_d    = '0;
                y_d    = '0;
                addr_d = '0;
            end else if (line_end_s) begin
                x_d    = '0;
                y_d    = y_q + YW'(1);
                addr_d = addr_q + ADDR_W'(1);
            end else begin
                x_d    = x_q + XW'(1);
                addr_d = addr_q + ADDR_W'(1);
            end
        end else begin
            addr_d = addr_q;
        end
`ifdef PIXEL_SRC_HBLANK_EN
        if (state_q == ST_BLANK) blank_d = blank_q + BW'(1);
        else                     blank_d = '0;
`endif
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
`ifdef PIXEL_SRC_HBLANK_EN
            blank_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
`ifdef PIXEL_SRC_HBLANK_EN
            blank_q <= blank_d;
`endif
        end
    end

    // Read pipeline, 2-entry skid buffer and done pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            inflight_q <= 1'b0;
            rd_mk_q    <= 3'b000;
            ent0_q     <= '0;
            ent1_q     <= '0;
            cnt_q      <= 2'd0;
            done_q     <= 1'b0;
        end else begin
            inflight_q <= issue_s;
            if (issue_s) begin
                rd_mk_q <= {(x_q == '0) && (y_q == '0), line_end_s, frame_end_s};
            end else begin
                rd_mk_q <= rd_mk_q;
            end
            done_q <= (state_q == ST_DRAIN) && eof_xfer_s;
            case (cnt_q)
                2'd0: begin
                    if (inflight_q && !pixel_ready) begin
                        ent0_q <= {mem_rdata, rd_mk_q};
                        cnt_q  <= 2'd1;
                    end else begin
                        cnt_q  <= 2'd0;
                    end
                end
                2'd1: begin
                    if (pop_s && inflight_q) begin
                        ent0_q <= {mem_rdata, rd_mk_q};
                    end else if (pop_s) begin
                        cnt_q  <= 2'd0;
                    end else if (inflight_q) begin
                        ent1_q <= {mem_rdata, rd_mk_q};
                        cnt_q  <= 2'd2;
                    end else begin
                        cnt_q  <= 2'd1;
                    end
                end
                2'd2: begin
                    if (pop_s) begin
                        ent0_q <= ent1_q;
                        cnt_q  <= 2'd1;
                    end else begin
                        cnt_q  <= 2'd2;
                    end
                end
                default: cnt_q <= 2'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_stream_source.sv
// Bench for pixel_stream_source: cycle table for a ready-high frame, then backpressure,
// mid-frame start, back-to-back and reset sequences checked against a raster reference model.
module tb_pixel_stream_source;

    localparam int W      = 4;
    localparam int H      = 2;
    localparam int AW     = 4;
    localparam int HB     = 2;
`ifdef PIXEL_SRC_HBLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif
    localparam int EXP_BLANK = BLANK_EN ? HB : 0;
    localparam int EXP_IDLE  = EXP_BLANK * (H - 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, mem_rd;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata = 8'h00;
    logic [7:0]    pixel;
    logic          pixel_valid;
    logic          pixel_ready = 1'b0;
    logic          sof, eol, eof;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         ready;
        bit         valid;
        logic [7:0] pix;
        logic [2:0] mk;
        bit         busy;
        bit         done;
    } vec_t;

    vec_t tbl[$];

    pixel_stream_source #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .HBLANK(HB)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .pixel(pixel), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .sof(sof), .eol(eol), .eof(eof)
    );

    always #5 clk = ~clk;

    // Frame RAM: contents are address + 0x10, one cycle read latency
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= 8'h10 + 8'(mem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_mem_rd"}, mem_rd, 0);
        chk({tag, "_valid"}, pixel_valid, 0);
        chk({tag, "_markers"}, {sof, eol, eof}, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_pixel"}, pixel, 0);
    endtask

    // One frame against the raster model; mode 0 ready high, 1 pattern 1,0,0, 2 random
    task automatic run_frame(input int mode, input bit mid_start, input bit chain_next, input bit started);
        int idx = 0;
        int cyc = 0;
        int idles = 0;
        bit seen_first = 1'b0;
        bit prev_stall = 1'b0;
        bit poked = 1'b0;
        bit fin = 1'b0;
        bit r;
        logic [7:0] prev_pix = 8'h00;
        logic [2:0] prev_mk = 3'b000;
        if (!started) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("first_mem_rd", mem_rd, 1);
        chk("first_addr", mem_addr, 0);
        chk("first_busy", busy, 1);
        chk("first_valid", pixel_valid, 0);
        while (!fin && cyc < 200) begin
            if (pixel_valid) begin
                if (prev_stall) begin
                    chk("stall_pixel", pixel, prev_pix);
                    chk("stall_markers", {sof, eol, eof}, prev_mk);
                end
                seen_first = 1'b1;
            end else if (seen_first) begin
                idles++;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            pixel_ready = r;
            start = mid_start && !poked && seen_first && (idx == 3);
            if (start) poked = 1'b1;
            if (pixel_valid && r) begin
                if (idx >= W * H) begin
                    chk("extra_transfer", idx, W * H - 1);
                    fin = 1'b1;
                end else begin
                    chk("pixel", pixel, 8'(16 + idx));
                    chk("markers", {sof, eol, eof},
                        {idx == 0, (idx % W) == W - 1, idx == W * H - 1});
                    if (eof) fin = 1'b1;
                end
                idx++;
            end
            prev_stall = pixel_valid && !r;
            prev_pix = pixel;
            prev_mk = {sof, eol, eof};
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("frame_complete", fin, 1);
        chk("transfer_count", idx, W * H);
        chk("done_pulse", done, 1);
        chk("busy_low_at_done", busy, 0);
        chk("valid_low_at_done", pixel_valid, 0);
        if (mode == 0 || !BLANK_EN) chk("idle_gap_cycles", idles, (mode == 0) ? EXP_IDLE : 0);
        if (chain_next) begin
            start = 1'b1;
        end else begin
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("stays_idle", busy, 0);
        end
    endtask

    initial begin
        // Ready-high frame as a cycle table, starting at the cycle after start is sampled
        tbl.push_back('{1'b1, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0});
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                tbl.push_back('{1'b1, 1'b1, 8'(16 + y * W + x),
                                {x == 0 && y == 0, x == W - 1, x == W - 1 && y == H - 1},
                                1'b1, 1'b0});
            end
            if (y < H - 1) begin
                for (int b = 0; b < EXP_BLANK; b++) tbl.push_back('{1'b1, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0});
            end
        end
        tbl.push_back('{1'b1, 1'b0, 8'h00, 3'b000, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0});

        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        reset = 1'b1;
        @(negedge clk);
        chk_idle_outputs("idle");

        pixel_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        foreach (tbl[i]) begin
            pixel_ready = tbl[i].ready;
            chk($sformatf("tbl%0d_valid", i), pixel_valid, tbl[i].valid);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].done);
            if (tbl[i].valid) begin
                chk($sformatf("tbl%0d_pixel", i), pixel, tbl[i].pix);
                chk($sformatf("tbl%0d_markers", i), {sof, eol, eof}, tbl[i].mk);
            end
            @(negedge clk);
        end

        run_frame(1, 1'b0, 1'b0, 1'b0);
        run_frame(2, 1'b1, 1'b1, 1'b0);
        run_frame(0, 1'b0, 1'b0, 1'b1);

        // Reset after the third transfer
        begin
            int xfers = 0;
            int guard = 0;
            pixel_ready = 1'b1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            while (xfers < 3 && guard < 50) begin
                if (pixel_valid) xfers++;
                if (xfers < 3) @(negedge clk);
                guard++;
            end
            chk("pre_reset_transfers", xfers, 3);
            reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            chk_idle_outputs("midreset");
            @(negedge clk);
            chk("midreset_stays_idle", busy, 0);
        end
        run_frame(0, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) run_frame(2, k[0], 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
